core_reset_sequencer: RTL and testbench

CORE_RESET_SEQUENCER -- requirements
Module: core_reset_sequencer

---
 rtl/core_reset_seq_pkg.sv | 29 ++
 rtl/core_reset_seq_cnt.sv | 27 ++
 rtl/core_reset_sequencer.sv | 164 ++++++++++++++++
 tb/tb_core_reset_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_reset_seq_pkg.sv
// Shared types for the core reset sequencer: command and state encodings,
// count width and the pulse hold-length helper.
package core_reset_seq_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'd0,
        CMD_PULSE   = 2'd1,
        CMD_ASSERT  = 2'd2,
        CMD_RELEASE = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    // A zero request means "use the minimum", which the max() already covers.
    function automatic logic [CNT_W-1:0] clamp_hold(
        input logic [CNT_W-1:0] cyc,
        input logic [CNT_W-1:0] min_h
    );
        return (cyc < min_h) ? min_h : cyc;
    endfunction

endpackage

// File: rtl/core_reset_seq_cnt.sv
// Loadable down-counter with zero flag, shared by the HOLD and SETTLE phases.
module core_reset_seq_cnt
    import core_reset_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/core_reset_sequencer.sv
// Core reset sequencer: HELD/HOLD/SETTLE/IDLE FSM driving a registered core_reset.
// Optional CORE_RESET_SEQ_COUNT_EN adds a saturating reset_count output.
module core_reset_sequencer
    import core_reset_seq_pkg::*;
#(
    parameter int MIN_HOLD = 16,
    parameter int SETTLE   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_cmd,
    input  logic [CNT_W-1:0] req_cycles,
    output logic             core_reset,
    output logic             busy,
    output logic             done
`ifdef CORE_RESET_SEQ_COUNT_EN
    ,
    output logic [31:0]      reset_count
`endif
);

    localparam logic [CNT_W-1:0] MIN_HOLD_C = CNT_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0] SETTLE_C   = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state;
    cmd_e             cmd;
    logic [CNT_W-1:0] held_cnt;
    logic [CNT_W-1:0] pulse_len;
    logic             accept;
    logic             held_ok;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    assign cmd       = cmd_e'(req_cmd);
    assign req_ready = (state == ST_IDLE) || (state == ST_HELD);
    assign accept    = req_valid && req_ready;
    assign pulse_len = clamp_hold(req_cycles, MIN_HOLD_C);
    assign held_ok   = (held_cnt >= MIN_HOLD_C);

    // Counter value is "cycles left minus one"; the phase ends on zero.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        unique case (state)
            ST_IDLE, ST_HELD: begin
                if (accept && cmd == CMD_PULSE) begin
                    cnt_load = 1'b1;
                    cnt_val  = pulse_len - CNT_ONE;
                end else if (accept && cmd == CMD_RELEASE
                             && state == ST_HELD) begin
                    cnt_load = 1'b1;
                    cnt_val  = held_ok ? SETTLE_C - CNT_ONE
                                       : MIN_HOLD_C - held_cnt - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = SETTLE_C - CNT_ONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SETTLE: cnt_dec = 1'b1;
        endcase
    end

    core_reset_seq_cnt u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_HELD;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            held_cnt   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        unique case (cmd)
                            CMD_PULSE: begin
                                state      <= ST_HOLD;
                                core_reset <= 1'b1;
                                busy       <= 1'b1;
                            end
                            CMD_ASSERT: begin
                                state      <= ST_HELD;
                                core_reset <= 1'b1;
                                held_cnt   <= '0;
                                done       <= 1'b1;
                            end
                            CMD_NOP, CMD_RELEASE: done <= 1'b1;
                        endcase
                    end
                end
                ST_HELD: begin
                    if (held_cnt != '1) held_cnt <= held_cnt + CNT_ONE;
                    if (accept) begin
                        unique case (cmd)
                            CMD_PULSE: begin
                                state <= ST_HOLD;
                                busy  <= 1'b1;
                            end
                            CMD_RELEASE: begin
                                busy <= 1'b1;
                                if (held_ok) begin
                                    state      <= ST_SETTLE;
                                    core_reset <= 1'b0;
                                end else begin
                                    state <= ST_HOLD;
                                end
                            end
                            CMD_NOP, CMD_ASSERT: done <= 1'b1;
                        endcase
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        state      <= ST_SETTLE;
                        core_reset <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef CORE_RESET_SEQ_COUNT_EN
    logic core_reset_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            core_reset_d <= 1'b1;
            reset_count  <= '0;
        end else begin
            core_reset_d <= core_reset;
            if (core_reset && !core_reset_d && reset_count != '1)
                reset_count <= reset_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_reset_sequencer.sv
// Self-checking bench for core_reset_sequencer: command table plus
// queued per-cycle waveform expectations for the multi-cycle sequences.
module tb_core_reset_sequencer;
    import core_reset_seq_pkg::*;

    // Expected outputs packed as {core_reset, req_ready, busy, done}
    localparam logic [3:0] E_HELD    = 4'b1100;
    localparam logic [3:0] E_HELD_DN = 4'b1101;
    localparam logic [3:0] E_HOLD    = 4'b1010;
    localparam logic [3:0] E_SETTLE  = 4'b0010;
    localparam logic [3:0] E_IDLE    = 4'b0100;
    localparam logic [3:0] E_IDLE_DN = 4'b0101;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_cmd;
    logic [15:0] req_cycles;
    logic        core_reset;
    logic        busy;
    logic        done;
`ifdef CORE_RESET_SEQ_COUNT_EN
    logic [31:0] reset_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic        v;
        cmd_e        cmd;
        logic [15:0] cyc;
        logic [3:0]  exp;
        string       name;
    } vec_t;

    vec_t vt[7];

    core_reset_sequencer #(
        .MIN_HOLD (16),
        .SETTLE   (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_cycles  (req_cycles),
        .core_reset  (core_reset),
        .busy        (busy),
        .done        (done)
`ifdef CORE_RESET_SEQ_COUNT_EN
        ,
        .reset_count (reset_count)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_n <= cyc_n + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic check_one(input string tag);
        logic [3:0] e;
        logic [3:0] a;
        e = exp_q.pop_front();
        a = {core_reset, req_ready, busy, done};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @cycle %0d: cr/rdy/bsy/dn got %b required %b",
                     tag, cyc_n, a, e);
        end
    endtask

    task automatic drain(input string tag, input bit drop);
        while (exp_q.size() > 0) begin
            @(posedge clock);
            #1;
            if (drop) req_valid = 1'b0;
            check_one(tag);
        end
    endtask

    task automatic push_n(input int n, input logic [3:0] e);
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // One accepted request: n_hi cycles of HOLD, n_settle of SETTLE, then done.
    task automatic req_wave(input cmd_e c, input logic [15:0] n,
                            input int n_hi, input int n_settle,
                            input bit keep, input string tag);
        req_valid  = 1'b1;
        req_cmd    = c;
        req_cycles = n;
        push_n(n_hi, E_HOLD);
        push_n(n_settle, E_SETTLE);
        exp_q.push_back(E_IDLE_DN);
        drain(tag, !keep);
    endtask

    task automatic one(input logic v, input cmd_e c, input logic [15:0] n,
                       input logic [3:0] e, input string tag);
        req_valid  = v;
        req_cmd    = c;
        req_cycles = n;
        exp_q.push_back(e);
        drain(tag, 1'b1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        push_n(n, E_HELD);
        drain("reset", 1'b1);
        reset = 1'b0;
    endtask

`ifdef CORE_RESET_SEQ_COUNT_EN
    task automatic check_count(input logic [31:0] want, input string tag);
        checks++;
        if (reset_count !== want) begin
            errors++;
            $display("FAIL %s: reset_count got %0d required %0d",
                     tag, reset_count, want);
        end
    endtask
`endif

    initial begin
        vt[0] = '{1'b1, CMD_NOP,     16'd0, E_IDLE_DN, "nop_idle"};
        vt[1] = '{1'b0, CMD_NOP,     16'd0, E_IDLE,    "quiet_idle"};
        vt[2] = '{1'b1, CMD_RELEASE, 16'd0, E_IDLE_DN, "release_idle"};
        vt[3] = '{1'b1, CMD_ASSERT,  16'd0, E_HELD_DN, "assert_idle"};
        vt[4] = '{1'b1, CMD_ASSERT,  16'd0, E_HELD_DN, "assert_held"};
        vt[5] = '{1'b1, CMD_NOP,     16'd0, E_HELD_DN, "nop_held"};
        vt[6] = '{1'b0, CMD_NOP,     16'd0, E_HELD,    "quiet_held"};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_cmd    = 2'd0;
        req_cycles = 16'd0;

        // Reset for 3 cycles, then 10 quiet cycles held in reset
        do_reset(3);
        push_n(10, E_HELD);
        drain("held_idle", 1'b1);

        // Held count reaches MIN_HOLD exactly: RELEASE goes straight to SETTLE
        push_n(6, E_HELD);
        drain("held_idle2", 1'b1);
        req_wave(CMD_RELEASE, 16'd0, 0, 8, 1'b0, "release_at_min");

        for (int i = 0; i < 7; i++)
            one(vt[i].v, vt[i].cmd, vt[i].cyc, vt[i].exp, vt[i].name);

        // PULSE from HELD restarts the count; core_reset never drops early
        req_wave(CMD_PULSE, 16'd20, 20, 8, 1'b0, "pulse20_held");

        req_wave(CMD_PULSE, 16'd40, 40, 8, 1'b0, "pulse40");
        req_wave(CMD_PULSE, 16'd0,  16, 8, 1'b0, "pulse0");
        req_wave(CMD_PULSE, 16'd5,  16, 8, 1'b0, "pulse5");
        req_wave(CMD_PULSE, 16'd17, 17, 8, 1'b0, "pulse17");

        // valid held through busy: ignored, then taken once on return to IDLE
        req_wave(CMD_PULSE, 16'd16, 16, 8, 1'b1, "pulse_hold_valid");
        req_wave(CMD_PULSE, 16'd16, 16, 8, 1'b0, "pulse_backtoback");

        // RELEASE at held count 4: 12 more high cycles, 8 settle, done
        do_reset(1);
        push_n(4, E_HELD);
        drain("held4", 1'b1);
        req_wave(CMD_RELEASE, 16'd0, 12, 8, 1'b0, "release_at4");

        // reset in the middle of a 40-cycle pulse
        req_valid  = 1'b1;
        req_cmd    = CMD_PULSE;
        req_cycles = 16'd40;
        push_n(10, E_HOLD);
        drain("pulse40_part", 1'b1);
        do_reset(1);
        push_n(1, E_HELD);
        drain("after_mid_hold_reset", 1'b1);

        // reset in the middle of SETTLE (RELEASE at held count 1)
        req_valid = 1'b1;
        req_cmd   = CMD_RELEASE;
        push_n(15, E_HOLD);
        push_n(3, E_SETTLE);
        drain("release_at1", 1'b1);
        do_reset(1);
        push_n(1, E_HELD);
        drain("after_mid_settle_reset", 1'b1);

`ifdef CORE_RESET_SEQ_COUNT_EN
        do_reset(1);
        check_count(32'd0, "count_after_reset");
        req_wave(CMD_RELEASE, 16'd0, 16, 8, 1'b0, "cnt_release");
        check_count(32'd0, "count_after_release");
        for (int i = 0; i < 3; i++)
            req_wave(CMD_PULSE, 16'd0, 16, 8, 1'b0, "cnt_pulse");
        check_count(32'd3, "count_three_pulses");
        one(1'b1, CMD_ASSERT, 16'd0, E_HELD_DN, "cnt_assert_idle");
        one(1'b0, CMD_NOP, 16'd0, E_HELD, "cnt_quiet");
        check_count(32'd4, "count_assert_idle");
        one(1'b1, CMD_ASSERT, 16'd0, E_HELD_DN, "cnt_assert_held");
        one(1'b0, CMD_NOP, 16'd0, E_HELD, "cnt_quiet2");
        check_count(32'd4, "count_assert_held");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
